indirect_reg_file: RTL and testbench
====================================

# indirect_reg_file

Parametrised successor to the 16×8 accumulator-indirect register file. It keeps two combinational read ports, one synchronous write port, and pointer-based indirect addressing through the top address. It adds four things: asynchronous reset, pointer post-increment/decrement with wrap-around, optional write-to-read bypass, and a one-cycle shadow-bank context save/restore/swap for interrupt entry and exit. It sits in the core datapath between decode and the ALU, in the same position as the current register file.

## Interface
- REG_ADDR_WIDTH, 4, address bits; NREGS = 2**REG_ADDR_WIDTH physical registers
- REG_WIDTH, 8, data width; must be >= REG_ADDR_WIDTH
- BYPASS, 0, 1 = read of a register being written this cycle returns wr_value; 0 = returns the stored (old) value
- SHADOW, 1, 1 = shadow bank and ctx_save/ctx_restore are implemented; 0 = those inputs are ignored and no shadow storage exists
- clk  input  1  clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- rx, ry  input  REG_ADDR_WIDTH each  read addresses
- wr_reg  input  REG_ADDR_WIDTH  write address
- wr_value  input  REG_WIDTH  write data
- wr_enable  input  1  write strobe
- ptr_op  input  2  pointer update: 00 none, 01 +1, 10 −1, 11 none (reserved)
- ctx_save  input  1  copy the core bank into the shadow bank
- ctx_restore  input  1  copy the shadow bank into the core bank
- rx_value, ry_value  output  REG_WIDTH  read data
- ptr_value  output  REG_WIDTH  current pointer register contents

## Operation
- Fixed indices: PTR = NREGS−2 is the pointer register; ALIAS = NREGS−1 is the indirect address.
- Address resolution, applied identically to rx, ry and wr_reg:
  - an address equal to ALIAS resolves to ptr[REG_ADDR_WIDTH−1:0];
  - any other address is direct.
  - Physical register ALIAS is reachable only through a pointer whose low bits equal ALIAS. There is no double indirection.
- Reads are combinational from the resolved index.
- With BYPASS=1, if wr_enable is high and the resolved write index equals a resolved read index, that read port returns wr_value.
- Write: on a rising edge with wr_enable=1, core[resolved wr] <= wr_value. Resolution uses the pre-edge pointer.
- Pointer update: with ptr_op = 01 or 10, ptr <= ptr ± 1 modulo 2**REG_WIDTH (0xFF+1 → 0x00, 0x00−1 → 0xFF). The full REG_WIDTH bits wrap; only the low bits are used for addressing.
- Priority within one edge, highest first:
  1. ctx_restore. Core <= shadow. Write and ptr_op are dropped. If ctx_save is also high, the banks swap: shadow <= old core.
  2. A write whose resolved index is PTR. The write wins and ptr_op is dropped.
  3. Otherwise a write to another register and ptr_op both take effect.
- ctx_save alone: shadow <= pre-edge core values. The write and ptr_op in the same cycle still update the core only.
- SHADOW=0: ctx_save and ctx_restore have no effect.
- Reset (rst_n low, asynchronous):
  - all core registers and all shadow registers = 0;
  - outputs therefore read 0 (ptr=0, and alias resolves to reg 0);
  - the reset dominates any in-flight write or context operation;
  - all state holds while rst_n is low.

## Timing
- Read latency 0 (combinational). Written data is visible on a read of the same register from the cycle after the write edge, or in the same cycle when BYPASS=1.
- ptr_value and any alias resolution reflect a pointer update from the cycle after the edge.
- Context save/restore/swap completes in a single edge. There is no busy state and no stall.
- Deassertion of rst_n is assumed synchronous to clk at system level. The first write can occur on the first edge after release.

## Test plan
- Reset mid-write: write reg 3=0xA5, then assert rst_n low between edges → rx=3 reads 0x00 immediately; ptr_value=0x00.
- Indirect with post-increment: write reg 14=0x05 and reg 5=0x11. Set rx=15 with ptr_op=01 and wr_reg=15, wr_value=0x22. Response: rx_value=0x11 before the edge; after the edge reg5=0x22 and ptr=0x06. Then set ptr_op=10 from ptr=0x00 → ptr=0xFF, and alias then resolves to physical reg 15.
- Pointer conflict: wr_reg=14, wr_value=0x30, ptr_op=01 with ptr=0x07 → ptr=0x30.
- Bypass: with BYPASS=1, wr_reg=2, rx=2, wr_value=0x5C in the same cycle → rx_value=0x5C before the edge. With BYPASS=0, rx_value shows the old value.
- Context: fill regs 0–15 with value i. Pulse ctx_save, then write reg 0=0xEE, then pulse ctx_restore → reg 0 reads 0x00. Pulse save and restore together with core≠shadow → the banks swap, and a second swap restores the original contents.
- Parameter sweep: REG_ADDR_WIDTH=3, REG_WIDTH=16 → PTR=6, ALIAS=7. The pointer wraps at 0xFFFF, and the alias uses ptr[2:0].

Source files
------------

// File: rtl/indirect_reg_file.sv
// Parametrised register file with pointer-indirect addressing through the top
// address, pointer post-increment/decrement, optional write bypass and a shadow bank.
module indirect_reg_file #(
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned REG_WIDTH      = 8,
  parameter bit          BYPASS         = 1'b0,
  parameter bit          SHADOW         = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] rx,
  input  logic [REG_ADDR_WIDTH-1:0] ry,
  input  logic [REG_ADDR_WIDTH-1:0] wr_reg,
  input  logic [REG_WIDTH-1:0]      wr_value,
  input  logic                      wr_enable,
  input  logic [1:0]                ptr_op,
  input  logic                      ctx_save,
  input  logic                      ctx_restore,
  output logic [REG_WIDTH-1:0]      rx_value,
  output logic [REG_WIDTH-1:0]      ry_value,
  output logic [REG_WIDTH-1:0]      ptr_value
);

  localparam int unsigned NREGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] PTR_IDX   = REG_ADDR_WIDTH'(NREGS - 2);
  localparam logic [REG_ADDR_WIDTH-1:0] ALIAS_IDX = REG_ADDR_WIDTH'(NREGS - 1);

  typedef enum logic [1:0] {
    PTR_HOLD = 2'b00,
    PTR_INC  = 2'b01,
    PTR_DEC  = 2'b10,
    PTR_RSVD = 2'b11
  } ptr_op_e;

  logic [REG_WIDTH-1:0] core      [NREGS];
  logic [REG_WIDTH-1:0] core_next [NREGS];
  logic [REG_WIDTH-1:0] shadow_q  [NREGS];

  logic [REG_WIDTH-1:0]      ptr;
  logic [REG_WIDTH-1:0]      ptr_stepped;
  logic [REG_ADDR_WIDTH-1:0] rx_idx;
  logic [REG_ADDR_WIDTH-1:0] ry_idx;
  logic [REG_ADDR_WIDTH-1:0] wr_idx;
  logic                      ptr_step;
  logic                      restore_en;
  ptr_op_e                   op;

  // Single level of indirection: the alias address maps through the pointer's
  // low bits, and the resolved index is never looked up again.
  function automatic logic [REG_ADDR_WIDTH-1:0] resolve(
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic [REG_ADDR_WIDTH-1:0] ptr_lo
  );
    return (addr == ALIAS_IDX) ? ptr_lo : addr;
  endfunction

  assign ptr       = core[PTR_IDX];
  assign ptr_value = ptr;
  assign op        = ptr_op_e'(ptr_op);

  assign rx_idx = resolve(rx,     ptr[REG_ADDR_WIDTH-1:0]);
  assign ry_idx = resolve(ry,     ptr[REG_ADDR_WIDTH-1:0]);
  assign wr_idx = resolve(wr_reg, ptr[REG_ADDR_WIDTH-1:0]);

  always_comb begin
    rx_value = core[rx_idx];
    ry_value = core[ry_idx];
    if (BYPASS && wr_enable && (wr_idx == rx_idx)) rx_value = wr_value;
    if (BYPASS && wr_enable && (wr_idx == ry_idx)) ry_value = wr_value;
  end

  always_comb begin
    ptr_step    = 1'b0;
    ptr_stepped = ptr;
    unique case (op)
      PTR_INC: begin
        ptr_step    = 1'b1;
        ptr_stepped = ptr + REG_WIDTH'(1);
      end
      PTR_DEC: begin
        ptr_step    = 1'b1;
        ptr_stepped = ptr - REG_WIDTH'(1);
      end
      PTR_HOLD, PTR_RSVD: begin
        ptr_step    = 1'b0;
        ptr_stepped = ptr;
      end
      default: begin
        ptr_step    = 1'b0;
        ptr_stepped = ptr;
      end
    endcase
  end

  assign restore_en = SHADOW && ctx_restore;

  // Restore overrides everything; otherwise a write landing on the pointer
  // register takes precedence over the pointer step in the same edge.
  always_comb begin
    core_next = core;
    if (restore_en) begin
      core_next = shadow_q;
    end else begin
      if (wr_enable) core_next[wr_idx] = wr_value;
      if (ptr_step && !(wr_enable && (wr_idx == PTR_IDX))) core_next[PTR_IDX] = ptr_stepped;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) core <= '{default: '0};
    else        core <= core_next;
  end

  generate
    if (SHADOW) begin : g_shadow
      logic [REG_WIDTH-1:0] shadow [NREGS];

      // Captures the pre-edge core, so save+restore together swaps the banks.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        shadow <= '{default: '0};
        else if (ctx_save) shadow <= core;
      end

      assign shadow_q = shadow;
    end else begin : g_no_shadow
      logic unused_ctx_save;
      assign unused_ctx_save = ctx_save;
      assign shadow_q        = '{default: '0};
    end
  endgenerate

endmodule

// File: tb/tb_indirect_reg_file.sv
// Bench for indirect_reg_file: directed scenarios then random traffic, two
// configurations checked against an array-based model of the register rules.
module tb_indirect_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rx, ry, wr_reg;
  logic [7:0]  wv0;
  logic [15:0] wv1;
  logic        we, cs, cr;
  logic [1:0]  ptr_op;
  logic [7:0]  rx0, ry0, pv0;
  logic [15:0] rx1, ry1, pv1;

  int errors = 0;
  int checks = 0;

  // Model state: [0] = 16x8 no bypass, [1] = 8x16 with bypass.
  int unsigned mc[2][16];
  int unsigned ms[2][16];

  always #5 clk = ~clk;

  indirect_reg_file #(
    .REG_ADDR_WIDTH(4), .REG_WIDTH(8), .BYPASS(1'b0), .SHADOW(1'b1)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx), .ry(ry), .wr_reg(wr_reg),
    .wr_value(wv0), .wr_enable(we), .ptr_op(ptr_op), .ctx_save(cs),
    .ctx_restore(cr), .rx_value(rx0), .ry_value(ry0), .ptr_value(pv0)
  );

  indirect_reg_file #(
    .REG_ADDR_WIDTH(3), .REG_WIDTH(16), .BYPASS(1'b1), .SHADOW(1'b1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx[2:0]), .ry(ry[2:0]), .wr_reg(wr_reg[2:0]),
    .wr_value(wv1), .wr_enable(we), .ptr_op(ptr_op), .ctx_save(cs),
    .ctx_restore(cr), .rx_value(rx1), .ry_value(ry1), .ptr_value(pv1)
  );

  function automatic int unsigned nr(input int d);
    return (d == 0) ? 16 : 8;
  endfunction

  function automatic int unsigned msk(input int d);
    return (d == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
  endfunction

  function automatic int unsigned res(input int d, input int unsigned a);
    int unsigned n;
    int unsigned ai;
    n  = nr(d);
    ai = a % n;
    if (ai == n - 1) return mc[d][n - 2] % n;
    return ai;
  endfunction

  function automatic int unsigned wval(input int d);
    return (d == 0) ? 32'(wv0) : 32'(wv1);
  endfunction

  function automatic int unsigned exp_rd(input int d, input int unsigned a);
    if (d == 1 && we && res(d, 32'(wr_reg)) == res(d, a)) return wval(d);
    return mc[d][res(d, a)];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) begin
        mc[d][i] = 0;
        ms[d][i] = 0;
      end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int unsigned n, p, wi, t;
      n  = nr(d);
      p  = mc[d][n - 2];
      wi = res(d, 32'(wr_reg));
      if (cr) begin
        for (int i = 0; i < 16; i++) begin
          t = ms[d][i];
          if (cs) ms[d][i] = mc[d][i];
          mc[d][i] = t;
        end
      end else begin
        if (cs) for (int i = 0; i < 16; i++) ms[d][i] = mc[d][i];
        if (we) mc[d][wi] = wval(d);
        if ((ptr_op == 2'b01 || ptr_op == 2'b10) && !(we && wi == n - 2))
          mc[d][n - 2] = ((ptr_op == 2'b01) ? p + 1 : p - 1) & msk(d);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rx0"}, 16'(rx0), 16'(exp_rd(0, 32'(rx))));
    chk({tag, ".ry0"}, 16'(ry0), 16'(exp_rd(0, 32'(ry))));
    chk({tag, ".pv0"}, 16'(pv0), 16'(mc[0][14]));
    chk({tag, ".rx1"}, rx1, 16'(exp_rd(1, 32'(rx))));
    chk({tag, ".ry1"}, ry1, 16'(exp_rd(1, 32'(ry))));
    chk({tag, ".pv1"}, pv1, 16'(mc[1][6]));
  endtask

  task automatic set_in(input logic [3:0] a_rx, input logic [3:0] a_ry,
                        input logic [3:0] a_wr, input logic a_we,
                        input int unsigned v, input logic [1:0] op,
                        input logic a_cs, input logic a_cr);
    rx = a_rx; ry = a_ry; wr_reg = a_wr; we = a_we;
    wv0 = v[7:0]; wv1 = v[15:0]; ptr_op = op; cs = a_cs; cr = a_cr;
  endtask

  task automatic step(input string tag);
    #2 check_outputs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    set_in(4'd0, 4'd0, 4'd0, 1'b0, 0, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_outputs("reset");
    chk("reset.pv0_const", 16'(pv0), 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write then asynchronous reset between edges, with a write in flight.
    set_in(4'd3, 4'd0, 4'd3, 1'b1, 32'hA5, 2'b00, 1'b0, 1'b0);
    step("wr3");
    set_in(4'd3, 4'd14, 4'd0, 1'b0, 0, 2'b00, 1'b0, 1'b0);
    #2 chk("wr3.readback", 16'(rx0), 16'h00A5);
    rst_n = 1'b0;
    model_reset();
    #1 chk("rst_mid.rx0", 16'(rx0), 16'h0000);
    chk("rst_mid.pv0", 16'(pv0), 16'h0000);
    set_in(4'd3, 4'd15, 4'd3, 1'b1, 32'h5A, 2'b01, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_outputs("rst_hold");
    set_in(4'd3, 4'd15, 4'd0, 1'b0, 0, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Indirect write with post-increment.
    set_in(4'd0, 4'd0, 4'd14, 1'b1, 32'h05, 2'b00, 1'b0, 1'b0); step("ptr5");
    set_in(4'd0, 4'd0, 4'd5,  1'b1, 32'h11, 2'b00, 1'b0, 1'b0); step("r5");
    set_in(4'd15, 4'd5, 4'd15, 1'b1, 32'h22, 2'b01, 1'b0, 1'b0);
    #1 chk("ind.pre_edge_rx0", 16'(rx0), 16'h0011);
    step("ind");
    set_in(4'd5, 4'd15, 4'd0, 1'b0, 0, 2'b00, 1'b0, 1'b0);
    #1 chk("ind.r5", 16'(rx0), 16'h0022);
    chk("ind.ptr", 16'(pv0), 16'h0006);
    step("ind_after");

    // Decrement from zero wraps; alias then reaches physical register 15.
    set_in(4'd0, 4'd0, 4'd14, 1'b1, 32'h0, 2'b00, 1'b0, 1'b0); step("ptr0");
    set_in(4'd0, 4'd0, 4'd0, 1'b0, 0, 2'b10, 1'b0, 1'b0);     step("dec");
    #1 chk("wrap_dn.pv0", 16'(pv0), 16'h00FF);
    chk("wrap_dn.pv1", pv1, 16'hFFFF);
    set_in(4'd15, 4'd7, 4'd15, 1'b1, 32'h3C, 2'b00, 1'b0, 1'b0); step("alias_wr");
    set_in(4'd15, 4'd7, 4'd0, 1'b0, 0, 2'b01, 1'b0, 1'b0);
    #1 chk("alias.r15", 16'(rx0), 16'h003C);
    step("inc");
    #1 chk("wrap_up.pv0", 16'(pv0), 16'h0000);
    chk("wrap_up.pv1", pv1, 16'h0000);

    // Write to the pointer register beats ptr_op.
    set_in(4'd0, 4'd0, 4'd14, 1'b1, 32'h07, 2'b00, 1'b0, 1'b0); step("ptr7");
    set_in(4'd0, 4'd0, 4'd14, 1'b1, 32'h30, 2'b01, 1'b0, 1'b0); step("conflict");
    #1 chk("conflict.pv0", 16'(pv0), 16'h0030);

    // Same-cycle read of the register being written.
    set_in(4'd2, 4'd1, 4'd2, 1'b1, 32'h5C, 2'b00, 1'b0, 1'b0);
    #1 chk("bypass.rx1", rx1, 16'h005C);
    step("bypass");

    // Context save / restore / swap.
    for (int i = 0; i < 16; i++) begin
      set_in(4'd0, 4'd0, 4'(i), 1'b1, 32'(i), 2'b00, 1'b0, 1'b0);
      step("fill");
    end
    set_in(4'd0, 4'd1, 4'd0, 1'b0, 0, 2'b00, 1'b1, 1'b0); step("save");
    set_in(4'd0, 4'd1, 4'd0, 1'b1, 32'hEE, 2'b00, 1'b0, 1'b0); step("wr0");
    set_in(4'd0, 4'd1, 4'd0, 1'b0, 0, 2'b00, 1'b0, 1'b1); step("restore");
    #1 chk("restore.r0", 16'(rx0), 16'h0000);
    set_in(4'd1, 4'd0, 4'd1, 1'b1, 32'h77, 2'b00, 1'b0, 1'b0); step("wr1");
    set_in(4'd1, 4'd0, 4'd0, 1'b0, 0, 2'b00, 1'b1, 1'b1); step("swap1");
    #1 chk("swap1.r1", 16'(rx0), 16'h0001);
    set_in(4'd1, 4'd0, 4'd0, 1'b0, 0, 2'b01, 1'b1, 1'b1); step("swap2");
    #1 chk("swap2.r1", 16'(rx0), 16'h0077);
    set_in(4'd1, 4'd0, 4'd0, 1'b0, 0, 2'b00, 1'b0, 1'b0); step("post_swap");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      set_in(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
             $urandom, 2'($urandom),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
